// File: rtl/fifo_sync_prog_if.sv
// Handshake, data, threshold and status signals of fifo_sync_prog.
// The master side drives the i_* signals; the FIFO (slave) drives the o_* signals.
interface fifo_sync_prog_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_wr_valid;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic [CW-1:0]    i_ae_thresh;
  logic [CW-1:0]    i_af_thresh;
  logic             i_err_clr;
  logic [CW-1:0]    o_count;
  logic             o_e_flag;
  logic             o_f_flag;
  logic             o_ae_flag;
  logic             o_af_flag;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en, i_ae_thresh, i_af_thresh, i_err_clr,
    input  o_wr_valid, o_rd_data, o_rd_valid, o_count, o_e_flag, o_f_flag,
           o_ae_flag, o_af_flag, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en, i_ae_thresh, i_af_thresh, i_err_clr,
    output o_wr_valid, o_rd_data, o_rd_valid, o_count, o_e_flag, o_f_flag,
           o_ae_flag, o_af_flag, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with standard or first-word-fall-through read, run-time
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_prog #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FWFT  = 0,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fifo_sync_prog_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_valid;
  logic             overflow;
  logic             underflow;
  logic             empty;
  logic             full;
  logic             rd_acc;
  logic             wr_acc;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_acc = bus.i_rd_en & ~empty;
  assign wr_acc = bus.i_wr_en & (~full | rd_acc);

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
      wr_valid  <= wr_acc;
      // A new event in the same cycle as a clear keeps the flag set.
      overflow  <= (bus.i_wr_en & ~wr_acc) | (overflow & ~bus.i_err_clr);
      underflow <= (bus.i_rd_en & empty)   | (underflow & ~bus.i_err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.o_rd_data  = mem[rd_ptr];
      assign bus.o_rd_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign bus.o_rd_data  = rd_data_q;
      assign bus.o_rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.o_wr_valid  = wr_valid;
  assign bus.o_count     = count;
  assign bus.o_e_flag    = empty;
  assign bus.o_f_flag    = full;
  assign bus.o_ae_flag   = (count <= bus.i_ae_thresh);
  assign bus.o_af_flag   = (count >= bus.i_af_thresh);
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based model of the FIFO.
module tb_fifo_sync_prog;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_sync_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  fifo_sync_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  fifo_sync_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  fifo_sync_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       m_wv, m_rv, m_ov, m_uf;
  logic [7:0] m_rdata;
  logic [4:0] ae_th, af_th;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wv = 1'b0; m_rv = 1'b0; m_ov = 1'b0; m_uf = 1'b0; m_rdata = '0;
  endtask

  task automatic model_step(input bit rn, input bit wr, input logic [7:0] d,
                            input bit rd, input bit clr);
    bit emp, ful, racc, wacc;
    if (!rn) begin
      model_reset();
    end else begin
      emp  = (q.size() == 0);
      ful  = (q.size() == DEPTH);
      racc = rd && !emp;
      wacc = wr && (!ful || racc);
      m_ov = (wr && !wacc) || (m_ov && !clr);
      m_uf = (rd && emp)   || (m_uf && !clr);
      if (racc) m_rdata = q.pop_front();
      m_rv = racc;
      if (wacc) q.push_back(d);
      m_wv = wacc;
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("std_count",  bus0.o_count,     n);
    check("fwft_count", bus1.o_count,     n);
    check("std_empty",  bus0.o_e_flag,    n == 0);
    check("fwft_empty", bus1.o_e_flag,    n == 0);
    check("std_full",   bus0.o_f_flag,    n == DEPTH);
    check("fwft_full",  bus1.o_f_flag,    n == DEPTH);
    check("std_ae",     bus0.o_ae_flag,   n <= int'(ae_th));
    check("fwft_ae",    bus1.o_ae_flag,   n <= int'(ae_th));
    check("std_af",     bus0.o_af_flag,   n >= int'(af_th));
    check("fwft_af",    bus1.o_af_flag,   n >= int'(af_th));
    check("std_wvalid", bus0.o_wr_valid,  m_wv);
    check("fwft_wvalid",bus1.o_wr_valid,  m_wv);
    check("std_ovf",    bus0.o_overflow,  m_ov);
    check("fwft_ovf",   bus1.o_overflow,  m_ov);
    check("std_udf",    bus0.o_underflow, m_uf);
    check("fwft_udf",   bus1.o_underflow, m_uf);
    check("std_rvalid", bus0.o_rd_valid,  m_rv);
    check("std_rdata",  bus0.o_rd_data,   m_rdata);
    check("fwft_rvalid",bus1.o_rd_valid,  n != 0);
    if (n != 0) check("fwft_rdata", bus1.o_rd_data, q[0]);
  endtask

  task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bus0.i_wr_en = wr; bus0.i_wr_data = d; bus0.i_rd_en = rd; bus0.i_err_clr = clr;
    bus1.i_wr_en = wr; bus1.i_wr_data = d; bus1.i_rd_en = rd; bus1.i_err_clr = clr;
    bus0.i_ae_thresh = ae_th; bus0.i_af_thresh = af_th;
    bus1.i_ae_thresh = ae_th; bus1.i_af_thresh = af_th;
  endtask

  // Drive one cycle, check the pre-edge state, then advance the model.
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd,
                       input bit clr, input bit rn);
    @(negedge clk);
    rst_n = rn;
    drive(wr, d, rd, clr);
    #1 compare_all();
    @(posedge clk);
    model_step(rn, wr, d, rd, clr);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int wp, rp;
    ae_th = 5'd3;
    af_th = 5'd13;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    model_reset();
    #2;
    check("rst_count", bus0.o_count, 0);
    check("rst_empty", bus0.o_e_flag, 1);
    check("rst_full",  bus0.o_f_flag, 0);
    check("rst_rdata", bus0.o_rd_data, 0);

    // Single write then read, standard mode.
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    #2 check("t1_wvalid", bus0.o_wr_valid, 1);
    check("t1_count", bus0.o_count, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #2 check("t1_rdata", bus0.o_rd_data, 8'h01);
    check("t1_rvalid", bus0.o_rd_valid, 1);
    check("t1_empty", bus0.o_e_flag, 1);
    idle();
    #2 check("t1_rvalid_drop", bus0.o_rd_valid, 0);

    // Overfill with 1..20, then drain 20.
    for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    #2 check("t2_count", bus0.o_count, 16);
    check("t2_full", bus0.o_f_flag, 1);
    check("t2_ovf", bus0.o_overflow, 1);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      if (i <= 16) begin
        #2 check("t2_order", bus0.o_rd_data, i);
      end
    end
    #2 check("t2_udf", bus0.o_underflow, 1);
    check("t2_count0", bus0.o_count, 0);

    // Clear sticky errors.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #2 check("t6_ovf_clr", bus0.o_overflow, 0);
    check("t6_udf_clr", bus0.o_underflow, 0);

    // FWFT fall-through visibility.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    #2 check("t3_rvalid", bus1.o_rd_valid, 1);
    check("t3_rdata", bus1.o_rd_data, 8'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #2 check("t3_pop_rvalid", bus1.o_rd_valid, 0);
    check("t3_pop_count", bus1.o_count, 0);

    // Threshold sweep 0..16, then retarget af at count 14.
    ae_th = 5'd3; af_th = 5'd13;
    for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k + 100), 1'b0, 1'b0, 1'b1);
    #2 check("t5_af_full", bus0.o_af_flag, 1);
    check("t5_ae_full", bus0.o_ae_flag, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #2 check("t5_af_14", bus0.o_af_flag, 1);
    af_th = 5'd16;
    idle();
    check("t5_af_retarget", bus0.o_af_flag, 0);
    cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous write and read for 40 cycles.
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i + 17), 1'b1, 1'b0, 1'b1);
    #2 check("t4_count", bus0.o_count, 16);
    check("t4_ovf", bus0.o_overflow, 0);

    // Drain to 9 words, then reset mid-burst.
    af_th = 5'd13;
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #2 check("t6_count9", bus0.o_count, 9);
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    #2 check("t6_rst_count", bus0.o_count, 0);
    check("t6_rst_empty", bus0.o_e_flag, 1);
    check("t6_rst_wvalid", bus0.o_wr_valid, 0);

    // Randomized traffic with shifting write/read pressure.
    wp = 50; rp = 50;
    for (int c = 0; c < 1200; c++) begin
      if (c % 100 == 0) begin
        wp = $urandom_range(10, 95);
        rp = $urandom_range(10, 95);
      end
      if (c % 37 == 0) begin
        ae_th = 5'($urandom_range(0, DEPTH));
        af_th = 5'($urandom_range(0, DEPTH));
      end
      cycle($urandom_range(0, 99) < wp, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 5,
            $urandom_range(0, 199) != 0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
- Next-generation single-clock FIFO for the shared buffering library.
- Generalises the current FIFO with:
  - a selectable read mode: standard registered-read or first-word-fall-through (FWFT);
  - almost-full/almost-empty thresholds set at run time through ports;
  - a count wide enough to represent a completely full FIFO;
  - sticky overflow/underflow error flags.
- Sits between producer and consumer blocks that need back-pressure and occupancy visibility.

Parameters:
- WIDTH, 8, data word width in bits (at least 1).
- DEPTH, 16, number of storage words; must be a power of 2 and at least 2.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), derived width of the count and threshold ports; not overridden.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset, sampled on the i_clk rising edge.
- i_wr_en  in  1  write request.
- i_wr_data  in  WIDTH  write data.
- o_wr_valid  out  1  high for one cycle after an accepted write.
- i_rd_en  in  1  read request (standard mode) or pop (FWFT mode).
- o_rd_data  out  WIDTH  read data.
- o_rd_valid  out  1  read-data qualifier; meaning depends on mode, see Behaviour.
- i_ae_thresh  in  CW  almost-empty threshold.
- i_af_thresh  in  CW  almost-full threshold.
- i_err_clr  in  1  clears both sticky error flags.
- o_count  out  CW  number of stored words, 0..DEPTH.
- o_e_flag  out  1  empty (count == 0).
- o_f_flag  out  1  full (count == DEPTH).
- o_ae_flag  out  1  count <= i_ae_thresh.
- o_af_flag  out  1  count >= i_af_thresh.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (i_rst_n = 0 at an edge):
  - read/write pointers, count, o_wr_valid, o_rd_valid, o_overflow and o_underflow all go to 0;
  - the standard-mode o_rd_data register goes to 0;
  - memory contents are not cleared.
- Reset takes priority over all other inputs, including mid-burst. After reset: o_e_flag = 1, o_f_flag = 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Full/empty are derived from the count register, not from pointer comparison.
- Write accepted when: i_wr_en AND (not full OR read accepted in the same cycle).
  - Accepted write: store at the write pointer, increment the pointer, o_wr_valid = 1 next cycle.
  - Rejected write: data dropped, o_overflow set.
- Read accepted when: i_rd_en AND not empty.
  - i_rd_en while empty sets o_underflow, including when a write lands in the same cycle.
  - A write into an empty FIFO never bypasses to the read side in the same cycle.
- Count update per edge: +1 for write only, -1 for read only, unchanged for both or neither. It never leaves 0..DEPTH.
- Standard mode (FWFT = 0):
  - Accepted read: o_rd_data <= mem[rd_ptr] at that edge; o_rd_valid = 1 for exactly the following cycle.
  - o_rd_valid = 0 on every other cycle; o_rd_data holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT = 1):
  - o_rd_data = mem[rd_ptr] combinationally; o_rd_valid = not empty.
  - i_rd_en with o_rd_valid pops the word; the next word is visible in the following cycle.
  - A write into an empty FIFO is visible (o_rd_valid = 1) the cycle after the write edge.
- Flags are combinational from the count register and the threshold ports.
  - Threshold changes take effect immediately.
  - i_ae_thresh = 0 makes ae equivalent to empty; i_af_thresh = DEPTH makes af equivalent to full; i_af_thresh = 0 forces af high.
- Sticky errors:
  - set on the edge that detects the event;
  - cleared by i_err_clr;
  - set wins over clear in the same cycle.

Test Plan:
- Reset, FWFT = 0, DEPTH = 16:
  - write 0x01 -> o_wr_valid = 1 next cycle, o_count = 1;
  - read -> o_rd_data = 0x01, o_rd_valid = 1 for one cycle, o_count = 0, o_e_flag = 1.
- Write 20 words 1..20 continuously from empty (FWFT = 0):
  - o_count reaches 16 and o_f_flag = 1;
  - words 17..20 dropped, o_overflow = 1;
  - reading 20 words returns 1..16 in order, then o_underflow = 1, o_count = 0.
- FWFT = 1, write 0xA5 at edge N:
  - o_rd_valid = 1 and o_rd_data = 0xA5 in cycle N+1 with no read issued;
  - pop -> o_rd_valid = 0, o_count = 0.
- Fill to 16, then assert i_wr_en and i_rd_en together for 40 cycles:
  - o_count stays 16, no overflow;
  - output sequence continuous across pointer wrap (at least two wraps).
- i_ae_thresh = 3, i_af_thresh = 13, step count 0..16:
  - o_ae_flag high for counts 0..3;
  - o_af_flag high for counts 13..16;
  - changing i_af_thresh to 16 at count 14 drops o_af_flag in the same cycle.
- Set both sticky errors, pulse i_err_clr -> both 0; a reset mid-burst with count 9 -> o_count = 0, o_e_flag = 1, flags cleared.
